// File: rtl/ctrl_set_gen.sv
// ctrl_set_gen: reset sequencer and clock-enable / set-pulse generator.
// After reset (or a software reset request) the block holds sreset for
// RST_HOLD cycles. It then produces a clk_en strobe every DIV cycles while
// run is high, samples data_src on each strobe, and turns each rising edge
// of set_req into a one-cycle set_out pulse.
module ctrl_set_gen #(
  parameter int DIV      = 4,
  parameter int RST_HOLD = 8,
  parameter int W        = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sw_rst_req,
  input  logic         run,
  input  logic         set_req,
  input  logic [W-1:0] data_src,
  output logic         sreset,
  output logic         clk_en,
  output logic         set_out,
  output logic [W-1:0] data_out,
  output logic         busy,
  output logic [15:0]  ce_count
);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Terminal counts, sized to hold DIV up to 256 and RST_HOLD up to 255.
  localparam logic [8:0] DIV_LAST  = 9'(DIV - 1);
  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

  state_t         state_q, state_d;
  logic [7:0]     hold_cnt_q, hold_cnt_d;
  logic [8:0]     div_cnt_q, div_cnt_d;
  logic [15:0]    ce_count_q, ce_count_d;
  logic [W-1:0]   data_q, data_d;
  logic           clk_en_q, clk_en_d;
  logic           set_out_q, set_out_d;
  logic           set_req_dly_q, set_req_dly_d;  // set_req delayed one cycle
  logic           sreset_q, sreset_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    div_cnt_d     = div_cnt_q;
    ce_count_d    = ce_count_q;
    data_d        = data_q;
    clk_en_d      = 1'b0;
    set_req_dly_d = set_req;
    // Rising edge of set_req; edges seen while holding reset are dropped.
    set_out_d     = set_req & ~set_req_dly_q & (state_q != S_HOLD);

    if (sw_rst_req) begin
      // Software reset wins over everything; the last sample is kept.
      state_d    = S_HOLD;
      hold_cnt_d = '0;
      div_cnt_d  = '0;
      ce_count_d = '0;
      set_out_d  = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = run ? S_RUN : S_PAUSE;
            hold_cnt_d = '0;
            div_cnt_d  = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end
        S_RUN: begin
          if (!run) begin
            // Freeze the divider phase so a later resume continues from it.
            state_d = S_PAUSE;
          end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            clk_en_d  = 1'b1;
            data_d    = data_src;
            if (ce_count_q != 16'hFFFF) begin
              ce_count_d = ce_count_q + 16'd1;
            end
          end else begin
            div_cnt_d = div_cnt_q + 9'd1;
          end
        end
        S_PAUSE: begin
          if (run) begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end

    // sreset/busy reflect the state being entered so they are registered.
    sreset_d = (state_d == S_HOLD);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_HOLD;
      hold_cnt_q    <= '0;
      div_cnt_q     <= '0;
      ce_count_q    <= '0;
      data_q        <= '0;
      clk_en_q      <= 1'b0;
      set_out_q     <= 1'b0;
      set_req_dly_q <= 1'b0;
      sreset_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      div_cnt_q     <= div_cnt_d;
      ce_count_q    <= ce_count_d;
      data_q        <= data_d;
      clk_en_q      <= clk_en_d;
      set_out_q     <= set_out_d;
      set_req_dly_q <= set_req_dly_d;
      sreset_q      <= sreset_d;
    end
  end

  assign sreset   = sreset_q;
  assign busy     = sreset_q;
  assign clk_en   = clk_en_q;
  assign set_out  = set_out_q;
  assign data_out = data_q;
  assign ce_count = ce_count_q;

endmodule

// File: tb/tb_ctrl_set_gen.sv
// Testbench for ctrl_set_gen: directed scenarios on a default instance and a
// DIV=1/RST_HOLD=1 instance, plus randomized traffic checked against a
// behavioural model.
`timescale 1ns/1ps
module tb_ctrl_set_gen;

  localparam int W      = 4;
  localparam int DIV_A  = 4;
  localparam int HOLD_A = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic         reset_a, sw_a, run_a, set_a;
  logic [W-1:0] data_a;
  logic         sreset_a, clk_en_a, set_out_a, busy_a;
  logic [W-1:0] data_out_a;
  logic [15:0]  ce_a;

  // Instance B: DIV=1, RST_HOLD=1
  logic         reset_b, sw_b, run_b, set_b;
  logic [W-1:0] data_b;
  logic         sreset_b, clk_en_b, set_out_b, busy_b;
  logic [W-1:0] data_out_b;
  logic [15:0]  ce_b;

  ctrl_set_gen #(.DIV(DIV_A), .RST_HOLD(HOLD_A), .W(W)) u_dut_a (
    .clk(clk), .reset(reset_a), .sw_rst_req(sw_a), .run(run_a),
    .set_req(set_a), .data_src(data_a), .sreset(sreset_a),
    .clk_en(clk_en_a), .set_out(set_out_a), .data_out(data_out_a),
    .busy(busy_a), .ce_count(ce_a)
  );

  ctrl_set_gen #(.DIV(1), .RST_HOLD(1), .W(W)) u_dut_b (
    .clk(clk), .reset(reset_b), .sw_rst_req(sw_b), .run(run_b),
    .set_req(set_b), .data_src(data_b), .sreset(sreset_b),
    .clk_en(clk_en_b), .set_out(set_out_b), .data_out(data_out_b),
    .busy(busy_b), .ce_count(ce_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected data_out / ce_count of instance A across directed scenarios
  logic [W-1:0] last_data_a;
  int           exp_ce_a;

  // Behavioural model state for the randomized test
  localparam int M_HOLD = 0, M_RUN = 1, M_PAUSE = 2;
  int           m_state, m_hold_left, m_phase, m_ce;
  bit           m_setd, m_clk_en, m_set_out;
  logic [W-1:0] m_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One model edge: hold lasts RST_HOLD edges, a strobe follows every DIV
  // running edges, set pulses follow rising set_req outside hold.
  task automatic model_step(input bit sw, input bit rn, input bit st, input logic [W-1:0] d);
    bit pulse;
    pulse    = st && !m_setd && (m_state != M_HOLD);
    m_setd   = st;
    m_clk_en = 1'b0;
    if (sw) begin
      m_state     = M_HOLD;
      m_hold_left = HOLD_A;
      m_phase     = 0;
      m_ce        = 0;
      pulse       = 1'b0;
    end else if (m_state == M_HOLD) begin
      m_hold_left = m_hold_left - 1;
      if (m_hold_left == 0) begin
        m_state = rn ? M_RUN : M_PAUSE;
        m_phase = 0;
      end
    end else if (m_state == M_RUN) begin
      if (!rn) begin
        m_state = M_PAUSE;
      end else begin
        m_phase = m_phase + 1;
        if (m_phase == DIV_A) begin
          m_phase  = 0;
          m_clk_en = 1'b1;
          m_data   = d;
          if (m_ce < 65535) m_ce = m_ce + 1;
        end
      end
    end else begin
      if (rn) m_state = M_RUN;
    end
    m_set_out = pulse;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({sreset_a, busy_a, clk_en_a, set_out_a, data_out_a, ce_a} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_a: got sreset=%b busy=%b clk_en=%b set_out=%b data=%h ce=%0d, expected 1 1 0 0 0 0",
               sreset_a, busy_a, clk_en_a, set_out_a, data_out_a, ce_a);
    end
    n_checks++;
    if ({sreset_b, busy_b, clk_en_b, set_out_b, data_out_b, ce_b} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_b: got sreset=%b busy=%b clk_en=%b set_out=%b data=%h ce=%0d, expected 1 1 0 0 0 0",
               sreset_b, busy_b, clk_en_b, set_out_b, data_out_b, ce_b);
    end
    $display("test_reset: reset state checked on both instances");
  endtask

  // Release reset between edges; edge 1 is the next rising edge.
  task automatic test_startup();
    bit strobe;
    last_data_a = '0;
    exp_ce_a    = 0;
    run_a = 1'b1; sw_a = 1'b0; set_a = 1'b0;
    reset_a = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      data_a = W'($urandom);
      tick();
      strobe = (e == 12) || (e == 16) || (e == 20);
      if (strobe) begin
        exp_ce_a++;
        last_data_a = data_a;
      end
      n_checks++;
      if ({sreset_a, busy_a} !== {2{1'(e < 8)}}) begin
        n_fail++;
        $display("FAIL startup_sreset edge %0d: got sreset=%b busy=%b, expected %b", e, sreset_a, busy_a, e < 8);
      end
      n_checks++;
      if (clk_en_a !== strobe) begin
        n_fail++;
        $display("FAIL startup_clk_en edge %0d: got %b, expected %b", e, clk_en_a, strobe);
      end
      n_checks++;
      if (data_out_a !== last_data_a || ce_a !== 16'(exp_ce_a)) begin
        n_fail++;
        $display("FAIL startup_data edge %0d: got data=%h ce=%0d, expected data=%h ce=%0d",
                 e, data_out_a, ce_a, last_data_a, exp_ce_a);
      end
    end
    $display("test_startup: 22 edges, ce_count=%0d", ce_a);
  endtask

  // Enters with div phase 2 (two edges after a strobe).
  task automatic test_pause();
    bit strobe;
    run_a = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      data_a = W'($urandom);
      tick();
      n_checks++;
      if (clk_en_a !== 1'b0 || data_out_a !== last_data_a || ce_a !== 16'(exp_ce_a)) begin
        n_fail++;
        $display("FAIL pause_hold cycle %0d: got clk_en=%b data=%h ce=%0d, expected 0 %h %0d",
                 k, clk_en_a, data_out_a, ce_a, last_data_a, exp_ce_a);
      end
    end
    run_a = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      data_a = W'($urandom);
      tick();
      strobe = (k == 3) || (k == 7);
      if (strobe) begin
        exp_ce_a++;
        last_data_a = data_a;
      end
      n_checks++;
      if (clk_en_a !== strobe || data_out_a !== last_data_a || ce_a !== 16'(exp_ce_a)) begin
        n_fail++;
        $display("FAIL pause_resume edge %0d: got clk_en=%b data=%h ce=%0d, expected %b %h %0d",
                 k, clk_en_a, data_out_a, ce_a, strobe, last_data_a, exp_ce_a);
      end
    end
    $display("test_pause: resumed without phase reset, ce_count=%0d", ce_a);
  endtask

  // Enters right after a strobe edge; strobes fall on k=4,8,12.
  task automatic test_set_pulse();
    bit strobe, pulse;
    for (int k = 1; k <= 12; k++) begin
      set_a  = (k <= 6) || (k == 12);
      data_a = W'($urandom);
      tick();
      strobe = (k % 4) == 0;
      pulse  = (k == 1) || (k == 12);
      if (strobe) begin
        exp_ce_a++;
        last_data_a = data_a;
      end
      n_checks++;
      if (set_out_a !== pulse || clk_en_a !== strobe) begin
        n_fail++;
        $display("FAIL set_pulse edge %0d: got set_out=%b clk_en=%b, expected %b %b",
                 k, set_out_a, clk_en_a, pulse, strobe);
      end
    end
    set_a = 1'b0;
    $display("test_set_pulse: single pulses, coincident with strobe on last edge");
  endtask

  // Enters right after a strobe edge.
  task automatic test_sw_rst();
    bit strobe;
    data_a = 4'hA;
    for (int k = 1; k <= 4; k++) tick();
    n_checks++;
    if (clk_en_a !== 1'b1 || data_out_a !== 4'hA) begin
      n_fail++;
      $display("FAIL swrst_setup: got clk_en=%b data=%h, expected 1 a", clk_en_a, data_out_a);
    end
    data_a = 4'h5;
    sw_a   = 1'b1;
    tick();
    sw_a = 1'b0;
    n_checks++;
    if ({sreset_a, busy_a, clk_en_a, set_out_a, data_out_a, ce_a} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 16'h0}) begin
      n_fail++;
      $display("FAIL swrst_entry: got sreset=%b busy=%b clk_en=%b set_out=%b data=%h ce=%0d, expected 1 1 0 0 a 0",
               sreset_a, busy_a, clk_en_a, set_out_a, data_out_a, ce_a);
    end
    last_data_a = 4'hA;
    exp_ce_a    = 0;
    for (int k = 1; k <= 17; k++) begin
      set_a  = (k >= 3);
      data_a = W'($urandom);
      tick();
      strobe = (k == 12) || (k == 16);
      if (strobe) begin
        exp_ce_a++;
        last_data_a = data_a;
      end
      n_checks++;
      if ({sreset_a, busy_a} !== {2{1'(k < 8)}} || set_out_a !== 1'b0) begin
        n_fail++;
        $display("FAIL swrst_hold edge %0d: got sreset=%b busy=%b set_out=%b, expected %b %b 0",
                 k, sreset_a, busy_a, set_out_a, k < 8, k < 8);
      end
      n_checks++;
      if (clk_en_a !== strobe || data_out_a !== last_data_a || ce_a !== 16'(exp_ce_a)) begin
        n_fail++;
        $display("FAIL swrst_resume edge %0d: got clk_en=%b data=%h ce=%0d, expected %b %h %0d",
                 k, clk_en_a, data_out_a, ce_a, strobe, last_data_a, exp_ce_a);
      end
    end
    set_a = 1'b0;
    $display("test_sw_rst: 8-cycle hold, data retained, strobes resumed");
  endtask

  task automatic test_async_reset();
    #2;
    reset_a = 1'b1;
    #1;
    n_checks++;
    if ({sreset_a, busy_a, clk_en_a, set_out_a, data_out_a, ce_a} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got sreset=%b busy=%b clk_en=%b set_out=%b data=%h ce=%0d, expected 1 1 0 0 0 0",
               sreset_a, busy_a, clk_en_a, set_out_a, data_out_a, ce_a);
    end
    tick();
    $display("test_async_reset: mid-run reset applied, repeating power-up sequence");
    test_startup();
  endtask

  task automatic test_random();
    int sw_left;
    reset_a = 1'b1; sw_a = 1'b0; run_a = 1'b1; set_a = 1'b0;
    tick();
    reset_a     = 1'b0;
    m_state     = M_HOLD;
    m_hold_left = HOLD_A;
    m_phase     = 0;
    m_ce        = 0;
    m_setd      = 1'b0;
    m_data      = '0;
    sw_left     = 0;
    for (int c = 0; c < 800; c++) begin
      if (sw_left > 0) begin
        sw_a = 1'b1;
        sw_left--;
      end else if ($urandom_range(0, 99) < 2) begin
        sw_a    = 1'b1;
        sw_left = $urandom_range(0, 3);
      end else begin
        sw_a = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) run_a = ~run_a;
      if ($urandom_range(0, 3) == 0) set_a = ~set_a;
      data_a = W'($urandom);
      tick();
      model_step(sw_a, run_a, set_a, data_a);
      n_checks++;
      if ({sreset_a, busy_a, clk_en_a, set_out_a} !==
          {m_state == M_HOLD, m_state == M_HOLD, m_clk_en, m_set_out}) begin
        n_fail++;
        $display("FAIL rand_ctrl cycle %0d: got sreset/busy/clk_en/set_out=%b%b%b%b, expected %b%b%b%b",
                 c, sreset_a, busy_a, clk_en_a, set_out_a,
                 m_state == M_HOLD, m_state == M_HOLD, m_clk_en, m_set_out);
      end
      n_checks++;
      if (data_out_a !== m_data || ce_a !== 16'(m_ce)) begin
        n_fail++;
        $display("FAIL rand_data cycle %0d: got data=%h ce=%0d, expected data=%h ce=%0d",
                 c, data_out_a, ce_a, m_data, m_ce);
      end
    end
    sw_a = 1'b0;
    $display("test_random: 800 cycles, final ce_count=%0d", ce_a);
  endtask

  task automatic test_div1();
    logic [W-1:0] exp_data;
    exp_data = '0;
    run_b   = 1'b1;
    reset_b = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      data_b = W'($urandom);
      tick();
      if (e >= 2) exp_data = data_b;
      n_checks++;
      if (sreset_b !== 1'b0 || clk_en_b !== 1'(e >= 2) || data_out_b !== exp_data || ce_b !== 16'(e - 1)) begin
        n_fail++;
        $display("FAIL div1 edge %0d: got sreset=%b clk_en=%b data=%h ce=%0d, expected 0 %b %h %0d",
                 e, sreset_b, clk_en_b, data_out_b, ce_b, e >= 2, exp_data, e - 1);
      end
    end
    $display("test_div1: strobe every cycle from edge 2");
  endtask

  // Continues instance B from edge 10; strobes so far equal edges-1.
  task automatic test_saturation();
    int exp_ce;
    for (int e = 11; e <= 65541; e++) begin
      tick();
      if (e == 65535 || e == 65536 || e == 65537 || e == 65541) begin
        exp_ce = (e - 1 > 65535) ? 65535 : e - 1;
        n_checks++;
        if (ce_b !== 16'(exp_ce) || clk_en_b !== 1'b1) begin
          n_fail++;
          $display("FAIL saturation edge %0d: got ce=%0d clk_en=%b, expected ce=%0d clk_en=1",
                   e, ce_b, clk_en_b, exp_ce);
        end
      end
    end
    $display("test_saturation: 65540 strobes, ce_count=%0d", ce_b);
  endtask

  initial begin
    reset_a = 1'b1; sw_a = 1'b0; run_a = 1'b0; set_a = 1'b0; data_a = '0;
    reset_b = 1'b1; sw_b = 1'b0; run_b = 1'b0; set_b = 1'b0; data_b = '0;
    last_data_a = '0;
    exp_ce_a    = 0;
    test_reset();
    test_startup();
    test_pause();
    test_set_pulse();
    test_sw_rst();
    test_async_reset();
    test_random();
    test_div1();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_set_gen.md
CTRL_SET_GEN -- requirements
Module: ctrl_set_gen

Interface
REQ-001 SHALL have parameter DIV, default 4, range 1..256: clock-enable period in clk cycles.
REQ-002 SHALL have parameter RST_HOLD, default 8, range 1..255: sreset hold length in clk cycles.
REQ-003 SHALL have parameter W, default 4: sampled data width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port sw_rst_req  input  1  synchronous request to re-issue sreset.
REQ-007 SHALL have port run  input  1  level; 1 allows clk_en generation.
REQ-008 SHALL have port set_req  input  1  level; each rising edge requests one set pulse.
REQ-009 SHALL have port data_src  input  W  raw data to be sampled.
REQ-010 SHALL have port sreset  output  1  synchronous reset for downstream registers.
REQ-011 SHALL have port clk_en  output  1  single-cycle enable strobe.
REQ-012 SHALL have port set_out  output  1  single-cycle synchronous set pulse.
REQ-013 SHALL have port data_out  output  W  data_src sampled at each strobe, stable while clk_en=1.
REQ-014 SHALL have port busy  output  1  1 while in HOLD.
REQ-015 SHALL have port ce_count  output  16  saturating count of clk_en strobes since last HOLD.

Function
REQ-016 SHALL implement three states: HOLD, RUN and PAUSE. All outputs SHALL be registered.
REQ-017 HOLD: sreset=1, busy=1, clk_en=0, set_out=0, and hold_cnt SHALL increment every cycle.
REQ-018 HOLD exit: on the edge where hold_cnt==RST_HOLD-1, the next state SHALL be RUN if run=1, else PAUSE. On that same edge, sreset and busy SHALL go to 0 and div_cnt SHALL clear to 0.
REQ-019 sreset SHALL therefore be high for exactly RST_HOLD cycles after reset deassertion or after a sw_rst_req edge.
REQ-020 RUN, per edge: if div_cnt==DIV-1, then div_cnt<=0, clk_en<=1, data_out<=data_src, and ce_count increments, saturating at 0xFFFF. Otherwise div_cnt++ and clk_en<=0.
REQ-021 With DIV=1, clk_en SHALL be 1 on every RUN cycle. The first strobe SHALL appear DIV edges after entering RUN.
REQ-022 RUN with run=0: the next state SHALL be PAUSE, clk_en<=0, and div_cnt SHALL be frozen.
REQ-023 PAUSE with run=1: the next state SHALL be RUN, and counting SHALL resume from the frozen div_cnt. No phase reset.
REQ-024 set edge detect: set_req_d SHALL register set_req every cycle in all states. set_out SHALL be set_req & ~set_req_d, gated by state!=HOLD, with 1-cycle latency. Edges arriving during HOLD SHALL be discarded.
REQ-025 set_out and clk_en SHALL be independent; both may be 1 in the same cycle.
REQ-026 sw_rst_req=1 in any state SHALL have highest priority. Next state SHALL be HOLD with hold_cnt=0, div_cnt=0, ce_count=0, clk_en=0 and set_out=0. data_out SHALL be retained.
REQ-027 sw_rst_req held high SHALL keep the block in HOLD, restarting hold_cnt each cycle. The RST_HOLD count SHALL start from the edge after sw_rst_req falls.
REQ-028 data_out SHALL change only on strobe edges and SHALL never change while clk_en=0.

Reset
REQ-029 reset=1 SHALL immediately force state=HOLD, hold_cnt=0, div_cnt=0, sreset=1, busy=1, clk_en=0, set_out=0, data_out=0, ce_count=0 and set_req_d=0.
REQ-030 reset asserted mid-RUN or mid-HOLD SHALL abort all activity. Behaviour after release SHALL be identical to power-up.

Verification
REQ-031 Defaults, run=1: reset released before edge 1 -> sreset=1 through edge 8 and 0 after edge 8; clk_en=1 after edges 12, 16, 20; ce_count=3 after edge 20.
REQ-032 DIV=1, RST_HOLD=1: release reset -> sreset clears at edge 1; clk_en=1 from edge 2 onward; data_out tracks data_src with 1-cycle lag.
REQ-033 Pause: run=0 with div_cnt=2, held 10 cycles, then run=1 -> no strobe while paused; next strobe 2 edges after resuming (div_cnt 2->3->strobe).
REQ-034 set_req 0->1 during RUN -> set_out=1 for exactly one cycle; set_req held high -> no further pulses; set_req rise during HOLD -> no pulse.
REQ-035 sw_rst_req pulse mid-RUN with data_out=0xA -> busy=1 and sreset=1 for 8 cycles; ce_count=0; data_out stays 0xA; strobes resume 4 edges after HOLD exit.
REQ-036 Saturation: force 65,540 strobes with DIV=1 -> ce_count=0xFFFF and does not wrap.
